myproject_mac_pipe: RTL and testbench

Parametrised, pipelined, multi-lane signed multiply-accumulate unit for the pruned-CNN datapath; successor to the single combinational `mul_*` cores. Each accepted beat multiplies LANES operand pairs, accumulates them per lane over a packet terminated by `in_last`, then rounds, shifts and saturates each sum to DOUT_W. Sits between the weight/activation streamers and the layer output buffer, with valid/ready handshakes on both sides.

---
 rtl/myproject_mac_pkg.sv | 40 ++++
 rtl/myproject_mac_lane.sv | 89 ++++++++
 rtl/myproject_mac_pipe.sv | 88 ++++++++
 tb/tb_myproject_mac_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myproject_mac_pkg.sv
// Shared arithmetic helpers for the pipelined multi-lane MAC: signed saturation and rounding shift.
package myproject_mac_pkg;

    localparam int unsigned ARITH_W = 64;

    typedef logic signed [ARITH_W-1:0] arith_t;

    // Clamp x into the signed range of a w-bit value (result stays ARITH_W wide).
    function automatic arith_t sat_s(input arith_t x, input int unsigned w);
        arith_t one;
        arith_t hi;
        arith_t lo;
        one = ARITH_W'(1);
        hi  = (one <<< (w - 1)) - one;
        lo  = -hi - one;
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Round half toward +inf, then arithmetic shift right by sh.
    function automatic arith_t round_shift(input arith_t x, input int unsigned sh);
        arith_t one;
        one = ARITH_W'(1);
        if (sh == 0) begin
            return x;
        end
        return (x + (one <<< (sh - 1))) >>> sh;
    endfunction

    // Bit offset of a lane within a packed multi-lane bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/myproject_mac_lane.sv
// One MAC lane: operand register, product pipeline, saturating accumulator, round/saturate output, ovf sticky.
module myproject_mac_lane
    import myproject_mac_pkg::*;
#(
    parameter int unsigned DIN0_W     = 16,
    parameter int unsigned DIN1_W     = 18,
    parameter int unsigned ACC_W      = 40,
    parameter int unsigned DOUT_W     = 16,
    parameter int unsigned FRAC_SHIFT = 14,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     adv,
    input  logic                     acc_fire,
    input  logic                     acc_last,
    input  logic signed [DIN0_W-1:0] a,
    input  logic signed [DIN1_W-1:0] b,
    output logic signed [DOUT_W-1:0] res,
    output logic                     ovf
);

    localparam int unsigned PROD_W = DIN0_W + DIN1_W;

    logic signed [DIN0_W-1:0] a_q;
    logic signed [DIN1_W-1:0] b_q;
    logic signed [ACC_W-1:0]  prod_q [MUL_STAGES];
    logic signed [ACC_W-1:0]  acc;
    logic                     sticky;

    logic signed [ACC_W:0]    sum_x;
    logic signed [ACC_W-1:0]  sum;
    arith_t                   sum_s;
    arith_t                   rnd;
    arith_t                   res_s;
    logic                     acc_sat;
    logic                     out_sat;
    logic signed [DOUT_W-1:0] res_c;

    // Operand capture and product pipeline; everything freezes while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            for (int s = 0; s < int'(MUL_STAGES); s++) begin
                prod_q[s] <= '0;
            end
        end else if (adv) begin
            a_q       <= a;
            b_q       <= b;
            prod_q[0] <= ACC_W'(PROD_W'(a_q) * PROD_W'(b_q));
            for (int s = 1; s < int'(MUL_STAGES); s++) begin
                prod_q[s] <= prod_q[s-1];
            end
        end
    end

    // Saturating accumulate plus the rounded/saturated result of that sum.
    always_comb begin
        sum_x   = (ACC_W+1)'(acc) + (ACC_W+1)'(prod_q[MUL_STAGES-1]);
        sum_s   = sat_s(ARITH_W'(sum_x), ACC_W);
        acc_sat = (sum_s != ARITH_W'(sum_x));
        sum     = ACC_W'(sum_s);
        rnd     = round_shift(ARITH_W'(sum), FRAC_SHIFT);
        res_s   = sat_s(rnd, DOUT_W);
        out_sat = (res_s != rnd);
        res_c   = DOUT_W'(res_s);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            sticky <= 1'b0;
            res    <= '0;
            ovf    <= 1'b0;
        end else if (acc_fire) begin
            if (acc_last) begin
                acc    <= '0;
                sticky <= 1'b0;
                res    <= res_c;
                ovf    <= sticky | acc_sat | out_sat;
            end else begin
                acc    <= sum;
                sticky <= sticky | acc_sat;
            end
        end
    end

endmodule

// File: rtl/myproject_mac_pipe.sv
// Pipelined multi-lane signed MAC top: shared valid/last pipeline, stall control, output handshake.
module myproject_mac_pipe
    import myproject_mac_pkg::*;
#(
    parameter int unsigned DIN0_W     = 16,
    parameter int unsigned DIN1_W     = 18,
    parameter int unsigned ACC_W      = 40,
    parameter int unsigned DOUT_W     = 16,
    parameter int unsigned FRAC_SHIFT = 14,
    parameter int unsigned LANES      = 4,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [LANES*DIN0_W-1:0]  din0,
    input  logic [LANES*DIN1_W-1:0]  din1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*DOUT_W-1:0]  dout,
    output logic [LANES-1:0]         dout_ovf
);

    // Operand register plus MUL_STAGES product registers.
    localparam int unsigned DEPTH = MUL_STAGES + 1;

    logic             stall;
    logic             adv;
    logic             accept;
    logic             acc_fire;
    logic             acc_last;
    logic             out_load;
    logic [DEPTH-1:0] vpipe;
    logic [DEPTH-1:0] lpipe;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign adv      = !stall;
    assign accept   = in_valid && in_ready;
    assign acc_fire = adv && vpipe[DEPTH-1];
    assign acc_last = lpipe[DEPTH-1];
    assign out_load = acc_fire && acc_last;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            vpipe <= '0;
            lpipe <= '0;
        end else if (adv) begin
            vpipe <= {vpipe[DEPTH-2:0], accept};
            lpipe <= {lpipe[DEPTH-2:0], accept && in_last};
        end
    end

    // A fresh result may replace one being handed off in the same cycle.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            out_valid <= 1'b0;
        end else if (out_load) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        myproject_mac_lane #(
            .DIN0_W    (DIN0_W),
            .DIN1_W    (DIN1_W),
            .ACC_W     (ACC_W),
            .DOUT_W    (DOUT_W),
            .FRAC_SHIFT(FRAC_SHIFT),
            .MUL_STAGES(MUL_STAGES)
        ) u_lane (
            .clk     (ap_clk),
            .rst     (ap_rst),
            .adv     (adv),
            .acc_fire(acc_fire),
            .acc_last(acc_last),
            .a       (din0[lane_lsb(i, DIN0_W) +: DIN0_W]),
            .b       (din1[lane_lsb(i, DIN1_W) +: DIN1_W]),
            .res     (dout[lane_lsb(i, DOUT_W) +: DOUT_W]),
            .ovf     (dout_ovf[i])
        );
    end

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Directed bench for myproject_mac_pipe: packet-level arithmetic model plus literal spot checks.
module tb_myproject_mac_pipe;

    localparam longint ACC_MAX   = 64'sd549755813887;   // 2^39-1
    localparam longint ACC_MIN   = -64'sd549755813888;
    localparam longint ROUND_ADD = 64'sd8192;           // 2^(14-1)
    localparam int     SHIFT     = 14;

    logic        ap_clk;
    logic        ap_rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [63:0] din0;
    logic [71:0] din1;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] dout;
    logic [3:0]  dout_ovf;

    myproject_mac_pipe dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .din0     (din0),
        .din1     (din1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
        .dout_ovf (dout_ovf)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_res = 0;
    int run = 0;
    int max_run = 0;
    int stall_waits = 0;

    longint      m_acc [4];
    logic  [3:0] m_sticky;
    logic [63:0] exp_d [$];
    logic  [3:0] exp_o [$];

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] p0(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic logic [71:0] p1(input int b0, input int b1, input int b2, input int b3);
        return {18'(b3), 18'(b2), 18'(b1), 18'(b0)};
    endfunction

    function automatic logic [63:0] r4(input int r0, input int r1, input int r2, input int r3);
        return {16'(r3), 16'(r2), 16'(r1), 16'(r0)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_acc[i] = 0;
        m_sticky = '0;
    endtask

    // Packet arithmetic: saturating sum of products, then round/shift/saturate on the closing beat.
    task automatic model_beat(input logic [63:0] d0, input logic [71:0] d1, input logic last);
        logic [63:0] d;
        logic [3:0]  o;
        longint a, b, s, r;
        logic f, g;
        d = '0;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            a = longint'($signed(d0[i*16 +: 16]));
            b = longint'($signed(d1[i*18 +: 18]));
            s = m_acc[i] + a * b;
            f = 1'b0;
            if (s > ACC_MAX) begin s = ACC_MAX; f = 1'b1; end
            else if (s < ACC_MIN) begin s = ACC_MIN; f = 1'b1; end
            if (last) begin
                r = (s + ROUND_ADD) >>> SHIFT;
                g = 1'b0;
                if (r > 32767) begin r = 32767; g = 1'b1; end
                else if (r < -32768) begin r = -32768; g = 1'b1; end
                d[i*16 +: 16] = 16'(r);
                o[i] = m_sticky[i] | f | g;
                m_acc[i] = 0;
                m_sticky[i] = 1'b0;
            end else begin
                m_acc[i] = s;
                m_sticky[i] = m_sticky[i] | f;
            end
        end
        if (last) begin
            exp_d.push_back(d);
            exp_o.push_back(o);
        end
    endtask

    // Offer one beat; it is taken on the first rising edge with in_ready high.
    task automatic send(input logic [63:0] d0, input logic [71:0] d1, input logic last);
        int guard;
        guard = 0;
        @(negedge ap_clk);
        in_valid = 1'b1;
        din0 = d0;
        din1 = d1;
        in_last = last;
        #1;
        while (!in_ready && guard < 200) begin
            stall_waits++;
            guard++;
            @(negedge ap_clk);
            #1;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready stuck at %b expected 1", in_ready);
        end else begin
            model_beat(d0, d1, last);
        end
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge ap_clk);
            #1;
            k++;
        end
        if (!out_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: out_valid never rose, got %b expected 1", name, out_valid);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge ap_clk);
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst = 1'b1;
        model_clear();
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    // Every handed-off result is checked against the model's queue.
    always begin
        @(negedge ap_clk);
        #2;
        if (!ap_rst && out_valid && out_ready) begin
            logic [63:0] ed;
            logic [3:0]  eo;
            n_res++;
            run++;
            if (run > max_run) max_run = run;
            n_vec++;
            if (exp_d.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got dout %h ovf %b expected no result", dout, dout_ovf);
            end else begin
                ed = exp_d.pop_front();
                eo = exp_o.pop_front();
                if (dout !== ed || dout_ovf !== eo) begin
                    n_err++;
                    $display("FAIL model_result: got dout %h ovf %b expected dout %h ovf %b",
                             dout, dout_ovf, ed, eo);
                end
            end
        end else begin
            run = 0;
        end
    end

    initial begin
        int base;
        ap_rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        din0 = '0;
        din1 = '0;
        out_ready = 1'b1;
        model_clear();
        idle(3);
        ap_rst = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_dout", dout, 64'd0);
        chk("reset_ovf", 64'(dout_ovf), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Single-beat packet: latency and rounding of 100*200.
        send(p0(100, 0, 0, 0), p1(200, 0, 0, 0), 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge ap_clk);
            #1;
            chk($sformatf("latency_edge%0d", k), 64'(out_valid), (k == 3) ? 64'd1 : 64'd0);
        end
        chk("single_dout", dout, r4(1, 0, 0, 0));
        chk("single_ovf", 64'(dout_ovf), 64'd0);
        idle(3);

        // Four beats of 2^28 per lane: output saturates on every lane.
        for (int k = 0; k < 4; k++)
            send(p0(16384, 16384, 16384, 16384), p1(16384, 16384, 16384, 16384), k == 3);
        wait_out("sat_wait");
        chk("sat_dout", dout, {4{16'h7fff}});
        chk("sat_ovf", 64'(dout_ovf), 64'hf);
        idle(3);

        // Rounding of negatives and negative output saturation.
        send(p0(-3, -1, 100, 32767), p1(16384, 8192, 200, -131072), 1'b1);
        wait_out("neg_wait");
        chk("neg_dout", dout, r4(-3, 0, 1, -32768));
        chk("neg_ovf", 64'(dout_ovf), 64'h8);
        idle(3);

        // Back-pressure: second result must wait behind the first.
        @(negedge ap_clk);
        out_ready = 1'b0;
        send(p0(100, 0, 0, 0), p1(200, 0, 0, 0), 1'b1);
        send(p0(-3, 0, 0, 0), p1(16384, 0, 0, 0), 1'b1);
        wait_out("stall_wait");
        idle(4);
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_hold_a", dout, r4(1, 0, 0, 0));
        @(negedge ap_clk);
        out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;
        #1;
        chk("stall_b_valid", 64'(out_valid), 64'd1);
        chk("stall_b_dout", dout, r4(-3, 0, 0, 0));
        chk("stall_b_in_ready", 64'(in_ready), 64'd0);
        @(negedge ap_clk);
        out_ready = 1'b1;
        idle(3);

        // Reset in the middle of a packet discards partial sums.
        send(p0(100, 5, 5, 5), p1(200, 7, 7, 7), 1'b0);
        send(p0(100, 5, 5, 5), p1(200, 7, 7, 7), 1'b0);
        do_reset();
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        base = n_res;
        send(p0(100, 0, 0, 0), p1(200, 0, 0, 0), 1'b1);
        wait_out("midreset_wait");
        chk("midreset_dout", dout, r4(1, 0, 0, 0));
        idle(6);
        chk("midreset_count", 64'(n_res - base), 64'd1);

        // Ten single-beat packets back to back at full throughput.
        stall_waits = 0;
        max_run = 0;
        base = n_res;
        for (int k = 0; k < 10; k++)
            send(p0(k * 1000, -k * 500, k, 32767), p1(20000, 3000, -131072, k), 1'b1);
        idle(8);
        chk("burst_in_ready_drops", 64'(stall_waits), 64'd0);
        chk("burst_consecutive", 64'(max_run), 64'd10);
        chk("burst_count", 64'(n_res - base), 64'd10);
        chk("queue_drained", 64'(exp_d.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
